riv_rdy_vld_multi_sink: RTL and testbench
=========================================

# riv_rdy_vld_multi_sink

Synthesizable multi-channel ready/valid sink with programmable backpressure, per-channel protocol checking and beat counting. It terminates up to NUM_CH independent ready/valid streams in loopback and bring-up builds. It generalises the single-channel simulation sink to hardware: it generates ready patterns, flags source protocol violations, and accumulates per-channel statistics for readout over the register bank.

## Interface

Parameters:
- NUM_CH, 4: number of independent channels, 1..8.
- DATA_WIDTH, 64: payload width per channel.
- CNT_WIDTH, 32: beat counter width per channel.
- LFSR_SEED, 16'hACE1: base seed for the random-ready LFSRs. Channel c uses LFSR_SEED ^ c, except that an all-zero result is replaced by 16'h0001.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- cfg_mode  in  2  ready mode, shared by all channels: 0 always ready, 1 never ready, 2 periodic, 3 random.
- cfg_period  in  8  periodic-mode period in cycles. A value of 0 is treated as 1.
- cfg_duty  in  8  periodic mode: ready is high for phase < cfg_duty.
- data_mask  in  DATA_WIDTH  bits compared and accumulated. A 0 bit is ignored.
- clr  in  1  synchronous clear of counters, errors and signatures.
- s_valid  in  NUM_CH  per-channel valid.
- s_ready  out  NUM_CH  per-channel ready, registered.
- s_data  in  NUM_CH*DATA_WIDTH  per-channel data; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- beat_cnt  out  NUM_CH*CNT_WIDTH  per-channel handshake count, saturating.
- err_drop  out  NUM_CH  sticky: valid deasserted while stalled.
- err_change  out  NUM_CH  sticky: masked data changed while stalled.
- signature  out  NUM_CH*DATA_WIDTH  per-channel data signature. Present only with the macro defined.

## Operation

- Handshake on channel c: s_valid[c] & s_ready[c] in the same cycle.
- Ready generation (next-state of the registered s_ready):
  - mode 0: 1.
  - mode 1: 0.
  - mode 2: per-channel phase counter counts 0..P-1 and wraps, with P = max(cfg_period, 1). Ready = (phase < cfg_duty).
    - If cfg_period shrinks so that phase >= P, phase reloads 0 on the next cycle.
    - cfg_duty >= P gives ready always high.
  - mode 3: per-channel 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle. Ready = lfsr[0].
- Phase counters and LFSRs run in every mode, so a mode switch takes effect on the next cycle with no restart.
- Stall tracking per channel:
  - pending <= s_valid & ~s_ready.
  - held <= s_data & data_mask, captured on the first cycle of a stall.
- Protocol checks, evaluated in a cycle where pending = 1:
  - s_valid = 0: set err_drop.
  - s_valid = 1 and ((s_data ^ held) & data_mask) != 0: set err_change.
  - Both can never fire in the same cycle.
- beat_cnt increments by 1 per handshake and saturates at all-ones. No wrap.
- clr takes priority over a same-cycle handshake or error: the result is count 0, errors 0, signature 0, and that beat is not counted. clr does not affect ready generation, pending or held.
- Channels are fully independent; simultaneous handshakes on all channels are each counted.

## Timing

- Reset values:
  - s_ready 0, beat_cnt 0, err_drop 0, err_change 0, signature 0.
  - phase 0, pending 0, held 0; LFSRs at their seeds.
- First possible ready: first clk edge after rst deasserts. In mode 0, s_ready is 1 from cycle 1.
- beat_cnt, signature and error flags update on the edge that ends the handshake or violation cycle, and are visible the cycle after.
- cfg changes: s_ready reflects a new cfg_mode, cfg_period or cfg_duty one cycle later.
- rst asserted mid-stall: all state is cleared immediately. After rst, a valid still held by the source is a new transfer, not a violation.

## Configuration

- RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN:
  - Defined: the signature port and logic exist. On each handshake, sig <= {sig[DATA_WIDTH-2:0], sig[DATA_WIDTH-1]} ^ (s_data & data_mask). Cleared by rst and clr.
  - Undefined: the signature port and all signature logic are omitted. All other behaviour is identical.

## Test plan

- Mode 0, channel 0 sends 10 consecutive beats of data 1..10 -> beat_cnt[0] = 10, no errors. With the macro, the signature matches the model's rotate-XOR of 1..10.
- Mode 2, cfg_period = 4, cfg_duty = 1, valid held high -> s_ready pattern 1000 repeating; 3 beats in 12 cycles; no errors.
- Mode 1, valid = 1 with data A5, then valid dropped -> err_drop = 1 the cycle after the drop and stays set; clr -> 0.
- Mode 1, data changes A5 -> A4 while stalled:
  - data_mask = FE -> no error.
  - data_mask = FF -> err_change = 1.
- beat_cnt at 2^CNT_WIDTH - 2, then 3 handshakes -> beat_cnt reads all-ones. clr coincident with a handshake -> beat_cnt = 0.
- Mode 3, 4 channels all valid for 1000 cycles, then rst mid-stall -> counts match the reference LFSR model; after rst, all outputs are 0 and no error is raised on the held valid.

Source files
------------

// File: rtl/riv_rdy_vld_multi_sink.sv
// Multi-channel ready/valid sink: programmable backpressure, protocol checks and beat counters.
// Optional per-channel data signature enabled by defining RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN.
module riv_rdy_vld_multi_sink #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     cfg_mode,
    input  logic [7:0]                     cfg_period,
    input  logic [7:0]                     cfg_duty,
    input  logic [DATA_WIDTH-1:0]          data_mask,
    input  logic                           clr,
    input  logic [NUM_CH-1:0]              s_valid,
    output logic [NUM_CH-1:0]              s_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
    output logic [NUM_CH*CNT_WIDTH-1:0]    beat_cnt,
    output logic [NUM_CH-1:0]              err_drop,
    output logic [NUM_CH-1:0]              err_change
`ifdef RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN
    ,
    output logic [NUM_CH*DATA_WIDTH-1:0]   signature
`endif
);

    typedef enum logic [1:0] {
        MODE_ALWAYS   = 2'd0,
        MODE_NEVER    = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_RANDOM   = 2'd3
    } mode_e;

    mode_e      w_mode;
    logic [7:0] w_period;

    assign w_mode   = mode_e'(cfg_mode);
    assign w_period = (cfg_period == 8'd0) ? 8'd1 : cfg_period;

    // A beat transfers on a cycle where s_valid[c] and the registered s_ready[c] are both high.
    // Once a source raises valid without ready it must hold valid and masked data until the transfer.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [15:0] SEED_RAW = LFSR_SEED ^ 16'(c);
        localparam logic [15:0] SEED     = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

        logic [DATA_WIDTH-1:0] w_data;
        logic [DATA_WIDTH-1:0] w_masked;
        logic                  w_hs;
        logic                  w_stall;
        logic                  w_drop;
        logic                  w_change;
        logic                  w_rdy_nxt;
        logic                  w_fb;
        logic [7:0]            w_phase_nxt;
        logic [CNT_WIDTH-1:0]  w_cnt_nxt;

        logic [15:0]           r_lfsr;
        logic [7:0]            r_phase;
        logic                  r_ready;
        logic                  r_pending;
        logic [DATA_WIDTH-1:0] r_held;
        logic [CNT_WIDTH-1:0]  r_cnt;
        logic                  r_drop;
        logic                  r_change;

        assign w_data   = s_data[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_masked = w_data & data_mask;
        assign w_hs     = s_valid[c] & r_ready;
        assign w_stall  = s_valid[c] & ~r_ready;
        assign w_drop   = r_pending & ~s_valid[c];
        assign w_change = r_pending & s_valid[c] & (((w_data ^ r_held) & data_mask) != '0);

        // Right-shifting Fibonacci LFSR, taps 16,14,13,11.
        assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

        // Also catches a phase left beyond a newly shrunk period.
        assign w_phase_nxt = (r_phase >= (w_period - 8'd1)) ? 8'd0 : (r_phase + 8'd1);

        assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : (r_cnt + CNT_WIDTH'(1));

        always_comb begin
            w_rdy_nxt = 1'b0;
            case (w_mode)
                MODE_ALWAYS:   w_rdy_nxt = 1'b1;
                MODE_NEVER:    w_rdy_nxt = 1'b0;
                MODE_PERIODIC: w_rdy_nxt = (r_phase < cfg_duty);
                MODE_RANDOM:   w_rdy_nxt = r_lfsr[0];
                default:       w_rdy_nxt = 1'b0;
            endcase
        end

        // Pattern generators free-run in every mode so mode switches need no restart.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lfsr  <= SEED;
                r_phase <= 8'd0;
                r_ready <= 1'b0;
            end else begin
                r_lfsr  <= {w_fb, r_lfsr[15:1]};
                r_phase <= w_phase_nxt;
                r_ready <= w_rdy_nxt;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pending <= 1'b0;
                r_held    <= '0;
            end else begin
                r_pending <= w_stall;
                if (w_stall && !r_pending) begin
                    r_held <= w_masked;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt    <= '0;
                r_drop   <= 1'b0;
                r_change <= 1'b0;
            end else if (clr) begin
                r_cnt    <= '0;
                r_drop   <= 1'b0;
                r_change <= 1'b0;
            end else begin
                if (w_hs) begin
                    r_cnt <= w_cnt_nxt;
                end
                if (w_drop) begin
                    r_drop <= 1'b1;
                end
                if (w_change) begin
                    r_change <= 1'b1;
                end
            end
        end

        assign s_ready[c]                           = r_ready;
        assign beat_cnt[c*CNT_WIDTH +: CNT_WIDTH]   = r_cnt;
        assign err_drop[c]                          = r_drop;
        assign err_change[c]                        = r_change;

`ifdef RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN
        logic [DATA_WIDTH-1:0] r_sig;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sig <= '0;
            end else if (clr) begin
                r_sig <= '0;
            end else if (w_hs) begin
                r_sig <= {r_sig[DATA_WIDTH-2:0], r_sig[DATA_WIDTH-1]} ^ w_masked;
            end
        end

        assign signature[c*DATA_WIDTH +: DATA_WIDTH] = r_sig;
`endif
    end

endmodule

// File: tb/tb_riv_rdy_vld_multi_sink.sv
// Directed and randomized bench for riv_rdy_vld_multi_sink with a cycle-level reference model.
// Signature checks are active when RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN is defined.
module tb_riv_rdy_vld_multi_sink;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int CW  = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        cfg_mode;
    logic [7:0]        cfg_period;
    logic [7:0]        cfg_duty;
    logic [DW-1:0]     data_mask;
    logic              clr;
    logic [NCH-1:0]    s_valid;
    logic [NCH-1:0]    s_ready;
    logic [NCH*DW-1:0] s_data;
    logic [NCH*CW-1:0] beat_cnt;
    logic [NCH-1:0]    err_drop;
    logic [NCH-1:0]    err_change;
`ifdef RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN
    logic [NCH*DW-1:0] signature;
`endif

    riv_rdy_vld_multi_sink #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_duty(cfg_duty), .data_mask(data_mask), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .beat_cnt(beat_cnt), .err_drop(err_drop), .err_change(err_change)
`ifdef RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN
        , .signature(signature)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: what each output should read in the current cycle.
    logic [NCH-1:0] m_ready, m_pend, m_drop, m_chg;
    logic [7:0]     m_phase [NCH];
    logic [15:0]    m_lfsr  [NCH];
    logic [DW-1:0]  m_held  [NCH];
    logic [CW-1:0]  m_cnt   [NCH];
    logic [DW-1:0]  m_sig   [NCH];

    logic [DW-1:0]  exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic b;
        b = x[0] ^ x[2] ^ x[3] ^ x[5];
        return {b, x[15:1]};
    endfunction

    function automatic logic [DW-1:0] rot_xor(input logic [DW-1:0] s, input logic [DW-1:0] d);
        return {s[DW-2:0], s[DW-1]} ^ d;
    endfunction

    task automatic model_reset();
        m_ready = '0; m_pend = '0; m_drop = '0; m_chg = '0;
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 8'd0;
            m_lfsr[c]  = ((SEED ^ 16'(c)) == 16'h0) ? 16'h0001 : (SEED ^ 16'(c));
            m_held[c]  = '0;
            m_cnt[c]   = '0;
            m_sig[c]   = '0;
        end
    endtask

    task automatic set_data(input int c, input logic [DW-1:0] d);
        s_data[c*DW +: DW] = d;
    endtask

    // Advance one clock: model computes next state from current inputs, then outputs are compared.
    task automatic step();
        logic [NCH-1:0] n_ready, n_pend, n_drop, n_chg;
        logic [7:0]     n_phase [NCH];
        logic [15:0]    n_lfsr  [NCH];
        logic [DW-1:0]  n_held  [NCH];
        logic [CW-1:0]  n_cnt   [NCH];
        logic [DW-1:0]  n_sig   [NCH];
        int             p;
        logic [DW-1:0]  d;
        logic           v;
        p = (cfg_period == 8'd0) ? 1 : int'(cfg_period);
        for (int c = 0; c < NCH; c++) begin
            d = s_data[c*DW +: DW];
            v = s_valid[c];
            n_pend[c] = v & ~m_ready[c];
            n_held[c] = (v && !m_ready[c] && !m_pend[c]) ? (d & data_mask) : m_held[c];
            n_drop[c] = m_drop[c];
            n_chg[c]  = m_chg[c];
            n_cnt[c]  = m_cnt[c];
            n_sig[c]  = m_sig[c];
            if (clr) begin
                n_drop[c] = 1'b0;
                n_chg[c]  = 1'b0;
                n_cnt[c]  = '0;
                n_sig[c]  = '0;
            end else begin
                if (m_pend[c] && !v) n_drop[c] = 1'b1;
                if (m_pend[c] && v && (((d ^ m_held[c]) & data_mask) != '0)) n_chg[c] = 1'b1;
                if (v && m_ready[c]) begin
                    if (int'(m_cnt[c]) < (1 << CW) - 1) n_cnt[c] = m_cnt[c] + 1'b1;
                    n_sig[c] = rot_xor(m_sig[c], d & data_mask);
                end
            end
            case (cfg_mode)
                2'd0:    n_ready[c] = 1'b1;
                2'd1:    n_ready[c] = 1'b0;
                2'd2:    n_ready[c] = (m_phase[c] < cfg_duty);
                default: n_ready[c] = m_lfsr[c][0];
            endcase
            n_phase[c] = ((int'(m_phase[c]) + 1) % p == 0 || int'(m_phase[c]) + 1 >= p) ? 8'd0 : m_phase[c] + 8'd1;
            n_lfsr[c]  = lfsr_next(m_lfsr[c]);
        end
        @(posedge clk);
        #1;
        m_ready = n_ready; m_pend = n_pend; m_drop = n_drop; m_chg = n_chg;
        m_phase = n_phase; m_lfsr = n_lfsr; m_held = n_held; m_cnt = n_cnt; m_sig = n_sig;
        chk("s_ready", 64'(s_ready), 64'(m_ready));
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s beat_cnt[%0d]", tag, c), 64'(beat_cnt[c*CW +: CW]), 64'(m_cnt[c]));
`ifdef RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN
            chk($sformatf("%s signature[%0d]", tag, c), 64'(signature[c*DW +: DW]), 64'(m_sig[c]));
`endif
        end
        chk({tag, " err_drop"}, 64'(err_drop), 64'(m_drop));
        chk({tag, " err_change"}, 64'(err_change), 64'(m_chg));
        chk({tag, " s_ready"}, 64'(s_ready), 64'(m_ready));
    endtask

    initial begin
        logic [NCH-1:0] hs;
        logic [11:0]    rvec, pvec;
        logic [CW-1:0]  cnt_before;
        logic [DW-1:0]  sig_exp;
        int             k, ones, r;

        rst = 1'b1; cfg_mode = 2'd0; cfg_period = 8'd4; cfg_duty = 8'd1;
        data_mask = '1; clr = 1'b0; s_valid = '0; s_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset beat_cnt all", 64'(beat_cnt), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Mode 0: ten back-to-back beats on channel 0.
        step();
        chk("mode0 ready from cycle 1", 64'(s_ready), 64'hF);
        s_valid[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            set_data(0, DW'(i));
            exp_q.push_back(DW'(i));
            step();
        end
        s_valid = '0;
        chk("mode0 beat_cnt[0]", 64'(beat_cnt[0 +: CW]), 64'(exp_q.size()));
        chk("mode0 errors", 64'({err_drop, err_change}), 64'(0));
        sig_exp = '0;
        while (exp_q.size() > 0) sig_exp = rot_xor(sig_exp, exp_q.pop_front());
`ifdef RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN
        chk("mode0 signature[0]", 64'(signature[0 +: DW]), 64'(sig_exp));
`endif
        check_all("mode0");

        // Mode 2, period 4, duty 1: ready pattern 1000 with valid held on channel 1.
        cfg_mode = 2'd2;
        step();
        s_valid[1] = 1'b1;
        set_data(1, 16'h1234);
        cnt_before = beat_cnt[CW +: CW];
        ones = 0;
        for (int i = 0; i < 12; i++) begin
            rvec[i] = s_ready[1];
            if (s_ready[1]) ones++;
            step();
        end
        s_valid = '0;
        k = 0;
        for (int i = 3; i >= 0; i--) if (rvec[i]) k = i;
        for (int i = 0; i < 12; i++) pvec[i] = ((i - k) % 4 == 0) && (i >= k);
        chk("periodic ready ones", 64'(ones), 64'(3));
        chk("periodic ready pattern", 64'(rvec), 64'(pvec));
        chk("periodic beats", 64'(beat_cnt[CW +: CW] - cnt_before), 64'(3));
        check_all("periodic");

        // Mode 1: valid dropped while stalled sets a sticky err_drop.
        cfg_mode = 2'd1;
        step();
        s_valid[2] = 1'b1;
        set_data(2, 16'h00A5);
        step();
        s_valid[2] = 1'b0;
        step();
        chk("drop set", 64'(err_drop[2]), 64'(1));
        chk("drop no change", 64'(err_change[2]), 64'(0));
        step();
        step();
        chk("drop sticky", 64'(err_drop[2]), 64'(1));
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("drop cleared", 64'(err_drop[2]), 64'(0));

        // Mode 1: A5 -> A4 while stalled, masked and unmasked LSB.
        data_mask = 16'hFFFE;
        s_valid[3] = 1'b1;
        set_data(3, 16'h00A5);
        step();
        set_data(3, 16'h00A4);
        step();
        chk("change masked", 64'(err_change[3]), 64'(0));
        s_valid[3] = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr beats drop", 64'(err_drop[3]), 64'(0));
        data_mask = 16'hFFFF;
        s_valid[3] = 1'b1;
        set_data(3, 16'h00A5);
        step();
        set_data(3, 16'h00A4);
        step();
        chk("change unmasked", 64'(err_change[3]), 64'(1));
        chk("change no drop", 64'(err_drop[3]), 64'(0));
        s_valid = '0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_all("after change");

        // Saturation at all-ones, then clr coincident with a handshake.
        cfg_mode = 2'd0;
        step();
        s_valid[0] = 1'b1;
        for (int i = 0; i < (1 << CW) - 2; i++) begin
            set_data(0, DW'($urandom));
            step();
        end
        chk("sat minus 2", 64'(beat_cnt[0 +: CW]), 64'((1 << CW) - 2));
        repeat (3) step();
        chk("sat all ones", 64'(beat_cnt[0 +: CW]), 64'((1 << CW) - 1));
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr with handshake", 64'(beat_cnt[0 +: CW]), 64'(0));
        step();
        chk("count after clr", 64'(beat_cnt[0 +: CW]), 64'(1));
        s_valid = '0;
        check_all("saturation");

        // Mode 3: random ready on all channels, mostly legal sources with rare violations.
        clr = 1'b1;
        step();
        clr = 1'b0;
        cfg_mode = 2'd3;
        step();
        s_valid = '1;
        for (int c = 0; c < NCH; c++) set_data(c, DW'($urandom));
        for (int i = 0; i < 1000; i++) begin
            hs = s_valid & m_ready;
            step();
            for (int c = 0; c < NCH; c++) begin
                if (hs[c] || !s_valid[c]) begin
                    s_valid[c] = 1'b1;
                    set_data(c, DW'($urandom));
                end else begin
                    r = $urandom_range(0, 199);
                    if (r == 0) set_data(c, s_data[c*DW +: DW] ^ 16'h0100);
                    else if (r == 1) s_valid[c] = 1'b0;
                end
            end
            if (i % 100 == 99) check_all("random");
        end
        check_all("random end");

        // Asynchronous reset mid-stall, sources keep valid asserted.
        s_valid = '1;
        rst = 1'b1;
        #2;
        model_reset();
        chk("rst beat_cnt", 64'(beat_cnt), 64'(0));
        chk("rst s_ready", 64'(s_ready), 64'(0));
        chk("rst errors", 64'({err_drop, err_change}), 64'(0));
`ifdef RIV_RDY_VLD_MULTI_SINK_SIGNATURE_EN
        chk("rst signature", 64'(signature), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            hs = s_valid & m_ready;
            step();
            for (int c = 0; c < NCH; c++) if (hs[c]) set_data(c, DW'($urandom));
        end
        chk("post rst err_drop", 64'(err_drop), 64'(0));
        chk("post rst err_change", 64'(err_change), 64'(0));
        check_all("post rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
